// File: rtl/imem_loader.sv
// Boot-time program loader: parses a length/words/checksum byte stream, writes
// instruction words to IMEM and releases the CPU reset once the checksum is good.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_cpu_rst_n,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] word_sh;
  logic [7:0]  csum;

  logic        accept;
  logic [15:0] len_full;
  logic        last_byte;
  logic        last_word;

  assign accept    = i_byte_valid & o_byte_ready;
  assign len_full  = {len[15:8], i_byte};
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = (word_cnt == len - 16'd1);

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      LEN_HI: if (accept) state_nxt = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if ({16'b0, len_full} > DEPTH_W) state_nxt = ERR;
          else if (len_full == 16'd0)       state_nxt = CHECK;
          else                              state_nxt = DATA;
        end
      end
      DATA:  if (accept && last_byte && last_word) state_nxt = CHECK;
      CHECK: if (accept) state_nxt = (csum == i_byte) ? DONE : ERR;
      DONE:  state_nxt = DONE;
      ERR:   state_nxt = ERR;
      default: state_nxt = LEN_HI;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) state <= LEN_HI;
    else       state <= state_nxt;
  end

  // Outputs are derived from the next state so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len          <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      word_sh      <= '0;
      csum         <= '0;
      o_byte_ready <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= BASE_ADDR;
      o_imem_wdata <= '0;
      o_cpu_rst_n  <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_imem_we    <= 1'b0;
      o_byte_ready <= !(state_nxt inside {DONE, ERR});
      o_done       <= (state_nxt == DONE);
      o_err        <= (state_nxt == ERR);
      o_cpu_rst_n  <= (state_nxt == DONE);
      case (state)
        LEN_HI: begin
          csum     <= '0;
          word_cnt <= '0;
          byte_cnt <= '0;
          if (accept) len[15:8] <= i_byte;
        end
        LEN_LO: if (accept) len[7:0] <= i_byte;
        DATA: begin
          if (accept) begin
            csum     <= csum ^ i_byte;
            byte_cnt <= byte_cnt + 2'd1;
            word_sh  <= {word_sh[15:0], i_byte};
            if (last_byte) begin
              o_imem_we    <= 1'b1;
              o_imem_addr  <= BASE_ADDR + {14'b0, word_cnt, 2'b00};
              o_imem_wdata <= {word_sh, i_byte};
              word_cnt     <= word_cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a stream-level reference model
// predicts IMEM writes and the final status; a monitor pops and compares writes.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 256;
  localparam int R_NONE = 0, R_DONE = 1, R_ERR = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        o_byte_ready, o_imem_we, o_cpu_rst_n, o_done, o_err;
  logic [31:0] o_imem_addr, o_imem_wdata;

  int  n_pass  = 0;
  int  n_total = 0;
  wr_t exp_q[$];
  wr_t last_wr = '{addr: BASE, data: 32'h0};

  imem_loader #(.BASE_ADDR(BASE), .IMEM_DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_rst_n  (o_cpu_rst_n),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge i_clk) begin
    wr_t e;
    if (o_imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'b0, o_imem_we}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", o_imem_addr, e.addr);
        check("write_data", o_imem_wdata, e.data);
      end
    end
  end

  // Reference model: interprets the byte stream by its format rules.
  task automatic model(input bq_t s, output int n_acc, output int res);
    int n;
    int need;
    logic [7:0] cs;
    wr_t w;
    res   = R_NONE;
    n_acc = s.size();
    if (s.size() < 2) return;
    n = int'({s[0], s[1]});
    if (n > DEPTH) begin
      n_acc = 2;
      res   = R_ERR;
      return;
    end
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (2 + 4*k + 3 < s.size()) begin
        w.addr = BASE + 32'(4*k);
        w.data = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
        cs     = cs ^ s[2+4*k] ^ s[3+4*k] ^ s[4+4*k] ^ s[5+4*k];
        exp_q.push_back(w);
        last_wr = w;
      end
    end
    need = 3 + 4*n;
    if (s.size() >= need) begin
      n_acc = need;
      res   = (s[need-1] == cs) ? R_DONE : R_ERR;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge i_clk);
      i_byte_valid = 1'b0;
    end
    @(negedge i_clk);
    i_byte_valid = 1'b1;
    i_byte       = b;
    t = 0;
    while (!o_byte_ready && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_byte_ready) begin
      check("accept_timeout", {31'b0, o_byte_ready}, 32'h1);
      return;
    end
    @(posedge i_clk);
  endtask

  task automatic run_stream(input bq_t s, input int max_gap, input string tag);
    int n_acc, res;
    model(s, n_acc, res);
    for (int i = 0; i < n_acc; i++)
      drive_byte(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    check({tag, "_writes_pending"}, exp_q.size(), 32'h0);
    check({tag, "_done"},   {31'b0, o_done},       (res == R_DONE) ? 32'h1 : 32'h0);
    check({tag, "_err"},    {31'b0, o_err},        (res == R_ERR)  ? 32'h1 : 32'h0);
    check({tag, "_cpu_rst_n"}, {31'b0, o_cpu_rst_n}, (res == R_DONE) ? 32'h1 : 32'h0);
    check({tag, "_ready"},  {31'b0, o_byte_ready}, (res == R_NONE) ? 32'h1 : 32'h0);
    check({tag, "_addr_hold"},  o_imem_addr,  last_wr.addr);
    check({tag, "_wdata_hold"}, o_imem_wdata, last_wr.data);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst        = 1'b1;
    i_byte_valid = 1'b0;
    @(negedge i_clk);
    check("rst_ready",     {31'b0, o_byte_ready}, 32'h0);
    check("rst_we",        {31'b0, o_imem_we},    32'h0);
    check("rst_addr",      o_imem_addr,           BASE);
    check("rst_wdata",     o_imem_wdata,          32'h0);
    check("rst_cpu_rst_n", {31'b0, o_cpu_rst_n},  32'h0);
    check("rst_done",      {31'b0, o_done},       32'h0);
    check("rst_err",       {31'b0, o_err},        32'h0);
    exp_q.delete();
    last_wr = '{addr: BASE, data: 32'h0};
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t good, bad, s;
    logic [15:0] n;
    logic [7:0]  cs, b;

    good = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    bad  = good;
    bad[10] = 8'h54;

    // Directed streams.
    do_reset();
    run_stream(good, 0, "good");
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_byte_valid = 1'b1;
      i_byte       = 8'($urandom);
      check("after_done_ready", {31'b0, o_byte_ready}, 32'h0);
    end
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    check("after_done_done",  {31'b0, o_done},      32'h1);
    check("after_done_cpu",   {31'b0, o_cpu_rst_n}, 32'h1);
    check("after_done_addr",  o_imem_addr,  32'h4);
    check("after_done_wdata", o_imem_wdata, 32'h0109_5020);

    do_reset();
    run_stream(bad, 0, "bad_csum");
    do_reset();
    run_stream('{8'h00, 8'h00, 8'h00}, 0, "empty");
    do_reset();
    run_stream('{8'h01, 8'h01}, 0, "too_long");
    do_reset();
    run_stream(good, 5, "gappy");

    // Abandon a load after six bytes, then replay the whole stream.
    do_reset();
    s = good[0:5];
    run_stream(s, 0, "partial");
    do_reset();
    run_stream(good, 0, "replay");

    // Randomized streams, some with corrupted checksum or oversized length.
    for (int r = 0; r < 12; r++) begin
      s.delete();
      if (r % 6 == 5) n = 16'($urandom_range(DEPTH + 1, 65535));
      else            n = 16'($urandom_range(0, 6));
      s.push_back(n[15:8]);
      s.push_back(n[7:0]);
      cs = 8'h00;
      if (n <= 16'(DEPTH)) begin
        for (int k = 0; k < 4*int'(n); k++) begin
          b = 8'($urandom);
          cs ^= b;
          s.push_back(b);
        end
        if ($urandom_range(0, 1) == 1) cs ^= 8'(1 << $urandom_range(0, 7));
        s.push_back(cs);
      end
      do_reset();
      run_stream(s, 3, $sformatf("rand%0d", r));
    end

    // Reset straight out of DONE drops the CPU reset release on that edge.
    do_reset();
    run_stream(good, 0, "final");
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("done_rst_cpu_rst_n", {31'b0, o_cpu_rst_n}, 32'h0);
    check("done_rst_done",      {31'b0, o_done},      32'h0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of the first instruction word written.
REQ-002 SHALL have parameter IMEM_DEPTH, default 256, giving the maximum number of 32-bit words accepted.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_byte_valid, input, 1 bit: the source presents a byte on i_byte.
REQ-006 SHALL have port i_byte, input, 8 bits: the program stream byte.
REQ-007 SHALL have port o_byte_ready, output, 1 bit: the loader accepts i_byte this cycle.
REQ-008 SHALL have port o_imem_we, output, 1 bit: one-cycle instruction memory write strobe.
REQ-009 SHALL have port o_imem_addr, output, 32 bits: instruction memory byte address.
REQ-010 SHALL have port o_imem_wdata, output, 32 bits: instruction word to write.
REQ-011 SHALL have port o_cpu_rst_n, output, 1 bit: active-low reset to the CPU top; held low until a load succeeds.
REQ-012 SHALL have port o_done, output, 1 bit: load finished with a good checksum.
REQ-013 SHALL have port o_err, output, 1 bit: load failed (bad length or checksum).

Function
REQ-014 A byte SHALL be accepted only on a cycle where i_byte_valid and o_byte_ready are both 1; idle gaps of any length between bytes SHALL be tolerated.
REQ-015 Stream format SHALL be: count N (2 bytes, MSB first), then N words (4 bytes each, MSB first), then 1 checksum byte equal to the XOR of all word bytes (header excluded).
REQ-016 FSM states SHALL be LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR; reset state is LEN_HI.
REQ-017 Transitions SHALL be: LEN_HI->LEN_LO on accept; LEN_LO->ERR if N>IMEM_DEPTH, ->CHECK if N==0, otherwise ->DATA; DATA->CHECK on accepting the 4th byte of word N-1; CHECK->DONE if checksum matches, otherwise ->ERR.
REQ-018 DONE and ERR SHALL be terminal; they are left only by i_rst.
REQ-019 o_byte_ready SHALL be 1 in LEN_HI, LEN_LO, DATA and CHECK, and 0 in DONE, ERR and during reset.
REQ-020 On acceptance of the 4th byte of word k, o_imem_we SHALL be 1 on the next cycle only, with o_imem_addr = BASE_ADDR + 4*k and o_imem_wdata = the assembled word.
REQ-021 o_imem_addr and o_imem_wdata SHALL hold their last values while o_imem_we is 0.
REQ-022 The word counter SHALL be 16 bits, and address arithmetic SHALL be 32-bit modulo 2^32.
REQ-023 The running checksum SHALL be an 8-bit XOR cleared in LEN_HI.
REQ-024 On entry to DONE: o_done=1 and o_cpu_rst_n=1, registered one cycle after the checksum byte is accepted.
REQ-025 On entry to ERR: o_err=1, and o_cpu_rst_n SHALL stay 0.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While i_rst=1 at a clock edge: state=LEN_HI, o_byte_ready=0, o_imem_we=0, o_imem_addr=BASE_ADDR, o_imem_wdata=0, o_cpu_rst_n=0, o_done=0, o_err=0, and the counters and checksum are cleared.
REQ-028 When i_rst is asserted mid-load, the partial load SHALL be abandoned, no further write strobe SHALL be issued, and the load restarts from LEN_HI; instruction memory contents are not cleared.
REQ-029 When i_rst is asserted in DONE, o_cpu_rst_n SHALL return to 0 on that edge.

Verification
REQ-030 Stream 00 02 20 08 00 05 01 09 50 20 55 -> writes (0x0,0x20080005) and (0x4,0x01095020), each with we high one cycle; then o_done=1, o_cpu_rst_n=1, o_byte_ready=0.
REQ-031 The same stream with checksum byte 0x54 -> the same two writes, then o_err=1, o_done=0, o_cpu_rst_n=0.
REQ-032 Stream 00 00 00 -> no write, o_done=1; stream 01 01 (N=257 with IMEM_DEPTH=256) -> ERR after the 2nd byte, no write.
REQ-033 REQ-030 stream with random 0-5 cycle valid gaps -> identical writes and result.
REQ-034 i_rst pulsed after 6 bytes of REQ-030, then the full stream replayed -> only the writes from the replay after the reset, then o_done=1.
REQ-035 Extra bytes presented after DONE -> o_byte_ready=0, no writes, and the outputs are unchanged.
